// File: rtl/shift_reg_n.sv
// shift_reg_n: WIDTH-bit shift register with hold/shift/load modes and counted burst shifts.
// Ports: clk, reset (sync, active-high); mode, d, si, start, count in; q, qbar, so, busy, done out.
// Optional macro SHIFT_REG_N_ROTATE_EN: shifts rotate and si is ignored.
module shift_reg_n #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             so,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  logic             r_dir;
  logic [CW-1:0]    r_rem;
  logic [WIDTH-1:0] r_q;
  logic             r_so;
  logic             r_busy;
  logic             r_done;

  logic             w_rin;
  logic             w_lin;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic             w_is_shift;
  logic             w_left;
  logic             w_dir;
  logic [WIDTH-1:0] w_sh_q;
  logic             w_sh_so;

`ifdef SHIFT_REG_N_ROTATE_EN
  assign w_rin = r_q[0];
  assign w_lin = r_q[WIDTH-1];
`else
  assign w_rin = si;
  assign w_lin = si;
`endif

  assign w_shr      = {w_rin, r_q[WIDTH-1:1]};
  assign w_shl      = {r_q[WIDTH-2:0], w_lin};
  assign w_is_shift = (mode == 2'b01) || (mode == 2'b10);
  assign w_left     = (mode == 2'b10);

  // Inside a burst the latched direction wins over mode.
  always_comb begin
    w_dir   = (r_state == S_SHIFT) ? r_dir : w_left;
    w_sh_q  = w_dir ? w_shl : w_shr;
    w_sh_so = w_dir ? r_q[WIDTH-1] : r_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_rem   <= '0;
      r_q     <= RESET_VAL;
      r_so    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && w_is_shift) begin
            if (count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_q   <= w_sh_q;
              r_so  <= w_sh_so;
              r_dir <= w_left;
              r_rem <= count - 1'b1;
              if (count == CW'(1)) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_SHIFT;
                r_busy  <= 1'b1;
              end
            end
          end else begin
            unique case (mode)
              2'b00: ;
              2'b01: begin
                r_q  <= w_shr;
                r_so <= r_q[0];
              end
              2'b10: begin
                r_q  <= w_shl;
                r_so <= r_q[WIDTH-1];
              end
              2'b11: r_q <= d;
            endcase
          end
        end
        S_SHIFT: begin
          r_q   <= w_sh_q;
          r_so  <= w_sh_so;
          r_rem <= r_rem - 1'b1;
          // remaining==1 means this edge does the last shift.
          if (r_rem == CW'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;
  assign so   = r_so;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_shift_reg_n.sv
// tb_shift_reg_n: directed self-checking bench for shift_reg_n (WIDTH=8).
// Expected values follow the SHIFT_REG_N_ROTATE_EN setting of the build.
module tb_shift_reg_n;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] d;
  logic       si;
  logic       start;
  logic [3:0] count;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       so;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

`ifdef SHIFT_REG_N_ROTATE_EN
  localparam logic [7:0] E_R81 = 8'hC0;
  localparam logic [7:0] E_L81 = 8'h03;
  localparam logic [7:0] E_B1  = 8'h03;
  localparam logic [7:0] E_B2  = 8'h06;
  localparam logic [7:0] E_B3  = 8'h0C;
  localparam logic [7:0] E_C1  = 8'h04;
  localparam logic [7:0] E_LNG = 8'h00;
`else
  localparam logic [7:0] E_R81 = 8'h40;
  localparam logic [7:0] E_L81 = 8'h02;
  localparam logic [7:0] E_B1  = 8'h02;
  localparam logic [7:0] E_B2  = 8'h04;
  localparam logic [7:0] E_B3  = 8'h08;
  localparam logic [7:0] E_C1  = 8'h84;
  localparam logic [7:0] E_LNG = 8'hFF;
`endif

  shift_reg_n #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .mode(mode), .d(d), .si(si),
    .start(start), .count(count), .q(q), .qbar(qbar), .so(so),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    start = 1'b0; mode = 2'b11; d = v;
    step();
    mode = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 2'b00; start = 1'b0;
    step();
    checks++;
    if ({q, qbar, so, busy, done} !== {8'h00, 8'hFF, 3'b000}) begin
      errors++;
      $display("FAIL reset q=%h qbar=%h so=%b busy=%b done=%b", q, qbar, so, busy, done);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({q, qbar, so, busy, done} !== {8'h00, 8'hFF, 3'b000}) begin
        errors++;
        $display("FAIL hold%0d q=%h qbar=%h so=%b busy=%b done=%b", i, q, qbar, so, busy, done);
      end
    end
  endtask

  task automatic test_load_shift();
    mode = 2'b11; d = 8'hA5;
    step();
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL load q=%h exp=a5", q); end
    mode = 2'b01; si = 1'b1;
    step();
    checks++;
    if ({q, so} !== {8'hD2, 1'b1}) begin
      errors++; $display("FAIL shr q=%h so=%b exp=d2/1", q, so);
    end
    mode = 2'b00;
    step();
    checks++;
    if ({q, so, qbar} !== {8'hD2, 1'b1, 8'h2D}) begin
      errors++; $display("FAIL hold_so q=%h so=%b qbar=%h", q, so, qbar);
    end
  endtask

  task automatic test_rotate();
    load(8'h81);
    mode = 2'b01; si = 1'b0;
    step();
    checks++;
    if ({q, so} !== {E_R81, 1'b1}) begin
      errors++; $display("FAIL right81 q=%h so=%b exp=%h/1", q, so, E_R81);
    end
    load(8'h81);
    mode = 2'b10; si = 1'b0;
    step();
    checks++;
    if ({q, so} !== {E_L81, 1'b1}) begin
      errors++; $display("FAIL left81 q=%h so=%b exp=%h/1", q, so, E_L81);
    end
  endtask

  task automatic test_burst();
    load(8'h81);
    start = 1'b1; mode = 2'b10; count = 4'd3; si = 1'b0;
    step();
    checks++;
    if ({q, so, busy, done} !== {E_B1, 3'b110}) begin
      errors++; $display("FAIL burst1 q=%h so=%b busy=%b done=%b", q, so, busy, done);
    end
    start = 1'b0; mode = 2'b11; d = 8'hFF;
    step();
    checks++;
    if ({q, so, busy, done} !== {E_B2, 3'b010}) begin
      errors++; $display("FAIL burst2 q=%h so=%b busy=%b done=%b", q, so, busy, done);
    end
    step();
    checks++;
    if ({q, so, busy, done} !== {E_B3, 3'b001}) begin
      errors++; $display("FAIL burst3 q=%h so=%b busy=%b done=%b", q, so, busy, done);
    end
    mode = 2'b00;
    step();
    checks++;
    if ({q, busy, done} !== {E_B3, 2'b00}) begin
      errors++; $display("FAIL burst_end q=%h busy=%b done=%b", q, busy, done);
    end
  endtask

  task automatic test_count1();
    load(8'h08);
    start = 1'b1; mode = 2'b01; count = 4'd1; si = 1'b1;
    step();
    checks++;
    if ({q, busy, done} !== {E_C1, 2'b01}) begin
      errors++; $display("FAIL count1 q=%h busy=%b done=%b exp=%h/0/1", q, busy, done, E_C1);
    end
    start = 1'b0; mode = 2'b00;
    step();
    checks++;
    if ({q, busy, done} !== {E_C1, 2'b00}) begin
      errors++; $display("FAIL count1_end q=%h busy=%b done=%b", q, busy, done);
    end
  endtask

  task automatic test_count0();
    load(8'h3C);
    start = 1'b1; mode = 2'b01; count = 4'd0;
    step();
    checks++;
    if ({q, busy, done} !== {8'h3C, 2'b01}) begin
      errors++; $display("FAIL count0 q=%h busy=%b done=%b exp=3c/0/1", q, busy, done);
    end
    start = 1'b1; mode = 2'b11; d = 8'h55; count = 4'd3;
    step();
    checks++;
    if ({q, busy, done} !== {8'h55, 2'b00}) begin
      errors++; $display("FAIL start_load q=%h busy=%b done=%b exp=55/0/0", q, busy, done);
    end
    start = 1'b0; mode = 2'b00;
  endtask

  task automatic test_abort();
    load(8'h0F);
    start = 1'b1; mode = 2'b01; count = 4'd6; si = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL abort_busy busy=%b done=%b exp=1/0", busy, done);
    end
    reset = 1'b1;
    step();
    reset = 1'b0; mode = 2'b00;
    checks++;
    if ({q, so, busy, done} !== {8'h00, 3'b000}) begin
      errors++; $display("FAIL abort q=%h so=%b busy=%b done=%b", q, so, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({q, busy, done} !== {8'h00, 2'b00}) begin
        errors++; $display("FAIL abort_after%0d q=%h busy=%b done=%b", i, q, busy, done);
      end
    end
  endtask

  task automatic test_long();
    load(8'h00);
    start = 1'b1; mode = 2'b10; count = 4'd10; si = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      start = 1'b0;
      checks++;
      if ({busy, done} !== {(i < 10), (i == 10)}) begin
        errors++; $display("FAIL long%0d busy=%b done=%b", i, busy, done);
      end
    end
    checks++;
    if (q !== E_LNG) begin
      errors++; $display("FAIL long_q q=%h exp=%h", q, E_LNG);
    end
    mode = 2'b00;
  endtask

  initial begin
    reset = 1'b1; mode = 2'b00; d = 8'h00; si = 1'b0;
    start = 1'b0; count = 4'd0;
    test_reset();
    test_load_shift();
    test_rotate();
    test_burst();
    test_count1();
    test_count0();
    test_abort();
    test_long();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
